// File: rtl/wb_pkg.sv
// wb_pkg: shared state encoding, default widths and byte-lane merge for the Wishbone RAM slave
package wb_pkg;
  typedef enum logic {IDLE, MERGE} state_t;
  localparam int WB_ADR_W = 16;
  localparam int WB_DAT_W = 16;
  function automatic logic [WB_DAT_W-1:0] byte_merge(
    input logic [WB_DAT_W-1:0]   old_d,
    input logic [WB_DAT_W-1:0]   new_d,
    input logic [WB_DAT_W/8-1:0] sel
  );
    for (int i = 0; i < WB_DAT_W/8; i++)
      byte_merge[i*8 +: 8] = sel[i] ? new_d[i*8 +: 8] : old_d[i*8 +: 8];
  endfunction
endpackage

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone B4 pipelined slave driving a single-port synchronous RAM
// Partial-word writes become a read followed by a merged write in the MERGE state.
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter int adr_width = WB_ADR_W,
  parameter int dat_width = WB_DAT_W,
  parameter int sel_width = dat_width/8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [adr_width-1:0] wb_adr_i,
  input  logic [dat_width-1:0] wb_dat_i,
  input  logic [sel_width-1:0] wb_sel_i,
  output logic                 wb_stall_o,
  output logic                 wb_ack_o,
  output logic [dat_width-1:0] wb_dat_o,
  output logic [adr_width-1:0] ram_a,
  output logic [dat_width-1:0] ram_d,
  input  logic [dat_width-1:0] ram_q,
  output logic                 ram_cen,
  output logic                 ram_wen
);
  state_t               r_state, w_state_nx;
  logic                 r_ack;
  logic [adr_width-1:0] r_adr;
  logic [dat_width-1:0] r_dat;
  logic [sel_width-1:0] r_sel;
  logic                 w_accept, w_full, w_null, w_partial, w_merge;
  assign w_merge    = (r_state == MERGE);
  assign wb_stall_o = w_merge;
  assign w_accept   = wb_cyc_i & wb_stb_i & ~w_merge;
  assign w_full     = wb_we_i & (&wb_sel_i);
  assign w_null     = wb_we_i & ~(|wb_sel_i);
  assign w_partial  = wb_we_i & ~w_full & ~w_null;
  always_comb begin
    w_state_nx = (w_accept & w_partial) ? MERGE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ack   <= (w_accept & ~w_partial) | w_merge;
    end
  end
  always_ff @(posedge clk) begin
    if (w_accept & w_partial) begin
      r_adr <= wb_adr_i;
      r_dat <= wb_dat_i;
      r_sel <= wb_sel_i;
    end
  end
  // A merge in flight still writes even if the master has dropped the cycle.
  assign ram_cen  = rst_n & ((w_accept & ~w_null) | w_merge);
  assign ram_wen  = rst_n & ((w_accept & w_full) | w_merge);
  assign ram_a    = w_merge ? r_adr : wb_adr_i;
  assign ram_d    = w_merge ? byte_merge(ram_q, r_dat, r_sel) : wb_dat_i;
  assign wb_ack_o = r_ack & wb_cyc_i;
  assign wb_dat_o = ram_q;
endmodule

// File: doc/wb_ram_slave.md
Name: wb_ram_slave

Overview:
- Wishbone B4 pipelined slave sitting directly upstream of the 64K x 16 single-port synchronous RAM.
- Decodes bus cycles into RAM cen/wen/a/d strobes and returns read data.
- RAM has no byte enables, so partial-word writes are done as an internal read-modify-write.
- An integration wrapper instantiates this block and the RAM side by side.

Parameters:
- adr_width, 16, word address width; matches RAM depth of 2**adr_width words.
- dat_width, 16, data width; must be a multiple of 8.
- sel_width, dat_width/8, byte-select width; derived, not overridden.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  request strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  adr_width  word address.
- wb_dat_i  in  dat_width  write data.
- wb_sel_i  in  sel_width  byte lane selects.
- wb_stall_o  out  1  request not accepted this cycle.
- wb_ack_o  out  1  request completed.
- wb_dat_o  out  dat_width  read data, valid while wb_ack_o is high for a read.
- ram_a  out  adr_width  RAM address.
- ram_d  out  dat_width  RAM write data.
- ram_q  in  dat_width  RAM read data; registered in the RAM, valid the cycle after a cen read.
- ram_cen  out  1  RAM chip enable, active high.
- ram_wen  out  1  RAM write enable, active high, qualified by ram_cen.

Behaviour:
- Accept condition: accept = wb_cyc_i & wb_stb_i & !wb_stall_o. At most one request is accepted per cycle.
- States: IDLE and MERGE; both reset to IDLE. wb_stall_o = (state == MERGE).
- Read, any sel, accepted in IDLE:
  - Same cycle, combinationally: ram_cen=1, ram_wen=0, ram_a=wb_adr_i.
  - Next cycle: wb_ack_o=1 and wb_dat_o=ram_q.
  - Latency 1; throughput 1 per cycle.
- Full write (sel all ones), accepted in IDLE:
  - Same cycle: ram_cen=1, ram_wen=1, ram_a=wb_adr_i, ram_d=wb_dat_i.
  - wb_ack_o asserted the next cycle.
- Null write (sel=0): no RAM access; wb_ack_o asserted the next cycle.
- Partial write (sel neither 0 nor all ones), accepted in IDLE:
  - Accept cycle: RAM read issued (cen=1, wen=0, a=wb_adr_i). adr, dat and sel are latched. Next state is MERGE.
  - MERGE cycle: ram_cen=1, ram_wen=1, ram_a=latched adr.
  - ram_d merges per byte lane: lane i takes latched dat if sel[i]=1, otherwise ram_q lane i.
  - wb_stall_o=1 during MERGE; no new request is accepted. Next state is IDLE.
  - wb_ack_o asserted the cycle after MERGE. Latency 2; occupies 2 bus cycles.
- wb_ack_o is registered:
  - ack_next = (accept & !partial_write) | (state == MERGE).
  - Exactly one ack per accepted request.
- wb_cyc_i deasserted:
  - No acceptance.
  - wb_ack_o is forced 0 in any cycle where wb_cyc_i=0, so a pending ack is dropped.
  - A MERGE already in progress still performs its RAM write, so memory is never left partially updated.
- ram_d = wb_dat_i in IDLE; ram_a = wb_adr_i in IDLE. Both are don't-care when ram_cen=0.
- wb_dat_o is a continuous pass-through of ram_q.
  - Value is defined only in read-ack cycles.
  - No reset value, because the RAM output is unreset.
  - During write-ack cycles it holds the last RAM read and must be ignored.
- Reset (rst_n low):
  - state=IDLE and wb_ack_o=0 immediately.
  - wb_stall_o=0.
  - ram_cen and ram_wen are forced 0 combinationally while rst_n is low, regardless of bus inputs.
- Reset asserted in MERGE: the merge write is abandoned and no ack is produced.
- No error or retry responses. The address space fully decodes 2**adr_width words and wraps trivially.

Decomposition:
- Package wb_pkg holds:
  - state enum {IDLE, MERGE}.
  - Default widths: WB_ADR_W=16, WB_DAT_W=16.
  - Function byte_merge(old, new, sel) returning the lane-merged word.
- No sub-module inside the block. The wrapper wb_ram connects wb_ram_slave to the RAM.

Test Plan:
- Reset with cyc/stb held high -> ram_cen=0, wb_ack_o=0, wb_stall_o=0 throughout reset; first acceptance on the first edge after release.
- Back-to-back full writes 0x0001=0xAAAA and 0x0002=0x5555, then pipelined reads of 0x0001 and 0x0002 on consecutive cycles -> acks on consecutive cycles returning 0xAAAA then 0x5555, stall never asserted.
- Preload 0x0010=0x1234; partial write sel=01, dat=0x00CD -> stall high exactly 1 cycle, one ack 2 cycles after accept; readback 0x12CD. Then sel=10, dat=0xEF00 -> readback 0xEFCD.
- Partial write to 0x0020 immediately followed by a read of 0x0020 held on the bus -> read accepted only after stall drops; returns the merged value.
- Null write (sel=00) to 0x0030 holding 0xBEEF -> ack after 1 cycle, ram_cen stays 0, readback 0xBEEF.
- wb_cyc_i dropped in the ack cycle of a read and during MERGE -> no ack seen; merge write still lands; next cycle accepts normally.
